// File: rtl/pipe_hold_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hold_ctrl
//   Hazard and hold controller for a five-stage pipeline. It turns the hazard
//   requests into one 2-bit hold command per pipeline register. When the
//   MEM-stage bus is waiting, it latches a taken jump and issues that redirect
//   once the wait clears. It also flags a bus wait that has lasted too long.
//
//   Hold encoding: 2'b00 none, 2'b01 wait (freeze), 2'b10 flush (bubble).
//
// Parameters
//   WAIT_TIMEOUT   1..255  consecutive mem_wait cycles that raise bus_timeout_o
//
// Ports
//   clk              in   1   rising-edge clock
//   rst_n            in   1   asynchronous active-low reset
//   mem_wait_i       in   1   MEM bus not ready, freeze everything
//   jump_req_i       in   1   EX resolved a taken jump / mispredict
//   jump_addr_i      in  32   redirect target, valid with jump_req_i
//   ex_busy_i        in   1   multi-cycle EX operation still running
//   load_use_i       in   1   ID detected a load-use hazard
//   hold_pc_o        out  2   hold command for PC
//   hold_if_id_o     out  2   hold command for IF/ID
//   hold_id_ex_o     out  2   hold command for ID/EX
//   hold_ex_mem_o    out  2   hold command for EX/MEM
//   hold_mem_wb_o    out  2   hold command for MEM/WB
//   pc_jump_en_o     out  1   redirect PC this cycle
//   pc_jump_addr_o   out 32   redirect target (0 when not redirecting)
//   jump_pend_o      out  1   a jump is latched, waiting for the bus
//   bus_timeout_o    out  1   single-cycle pulse when the wait reaches limit
// -----------------------------------------------------------------------------
module pipe_hold_ctrl #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_wait_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_busy_i,
  input  logic        load_use_i,
  output logic [1:0]  hold_pc_o,
  output logic [1:0]  hold_if_id_o,
  output logic [1:0]  hold_id_ex_o,
  output logic [1:0]  hold_ex_mem_o,
  output logic [1:0]  hold_mem_wb_o,
  output logic        pc_jump_en_o,
  output logic [31:0] pc_jump_addr_o,
  output logic        jump_pend_o,
  output logic        bus_timeout_o
);

  localparam logic [1:0] HOLD_NONE  = 2'b00;
  localparam logic [1:0] HOLD_WAIT  = 2'b01;
  localparam logic [1:0] HOLD_FLUSH = 2'b10;

  localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);
  localparam logic [7:0] TIMEOUT_M1  = 8'(WAIT_TIMEOUT - 1);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state;
  logic [31:0] pend_addr;
  logic [7:0]  wait_cnt;

  // State, latched jump target and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pend_addr <= '0;
      wait_cnt  <= '0;
    end else if (mem_wait_i) begin
      if (wait_cnt != TIMEOUT_CNT)
        wait_cnt <= wait_cnt + 8'd1;
      // A newer jump during the wait replaces the older one.
      if (jump_req_i) begin
        state     <= PEND;
        pend_addr <= jump_addr_i;
      end
    end else begin
      wait_cnt <= '0;
      state    <= RUN;
    end
  end

  // Hold and redirect decode, in priority order.
  // Gating with rst_n keeps every output at its idle value during reset,
  // even while the inputs are active.
  always_comb begin
    hold_pc_o      = HOLD_NONE;
    hold_if_id_o   = HOLD_NONE;
    hold_id_ex_o   = HOLD_NONE;
    hold_ex_mem_o  = HOLD_NONE;
    hold_mem_wb_o  = HOLD_NONE;
    pc_jump_en_o   = 1'b0;
    pc_jump_addr_o = '0;
    if (!rst_n) begin
      pc_jump_en_o = 1'b0;
    end else if (mem_wait_i) begin
      hold_pc_o     = HOLD_WAIT;
      hold_if_id_o  = HOLD_WAIT;
      hold_id_ex_o  = HOLD_WAIT;
      hold_ex_mem_o = HOLD_WAIT;
      hold_mem_wb_o = HOLD_WAIT;
    end else if (state == PEND) begin
      // jump_req_i this cycle comes from the same held instruction, so it is
      // ignored and the latched target is used.
      pc_jump_en_o   = 1'b1;
      pc_jump_addr_o = pend_addr;
      hold_if_id_o   = HOLD_FLUSH;
      hold_id_ex_o   = HOLD_FLUSH;
    end else if (jump_req_i) begin
      pc_jump_en_o   = 1'b1;
      pc_jump_addr_o = jump_addr_i;
      hold_if_id_o   = HOLD_FLUSH;
      hold_id_ex_o   = HOLD_FLUSH;
    end else if (ex_busy_i) begin
      hold_pc_o     = HOLD_WAIT;
      hold_if_id_o  = HOLD_WAIT;
      hold_id_ex_o  = HOLD_WAIT;
      hold_ex_mem_o = HOLD_FLUSH;
    end else if (load_use_i) begin
      hold_pc_o    = HOLD_WAIT;
      hold_if_id_o = HOLD_WAIT;
      hold_id_ex_o = HOLD_FLUSH;
    end
  end

  assign jump_pend_o = (state == PEND);

  // The pulse fires in the wait cycle that takes the counter to the limit.
  // After that the counter sits at the limit, so the compare fails until
  // mem_wait_i drops and the counter clears.
  assign bus_timeout_o = rst_n && mem_wait_i && (wait_cnt == TIMEOUT_M1);

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
module tb_pipe_hold_ctrl;

  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] W = 2'b01;
  localparam logic [1:0] F = 2'b10;

  // Packed {pc, if_id, id_ex, ex_mem, mem_wb}
  localparam logic [9:0] ALLN  = {N, N, N, N, N};
  localparam logic [9:0] ALLW  = {W, W, W, W, W};
  localparam logic [9:0] REDIR = {N, F, F, N, N};
  localparam logic [9:0] EXB   = {W, W, W, F, N};
  localparam logic [9:0] LU    = {W, W, F, N, N};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_wait_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        ex_busy_i;
  logic        load_use_i;
  logic [1:0]  hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o;
  logic        pc_jump_en_o;
  logic [31:0] pc_jump_addr_o;
  logic        jump_pend_o;
  logic        bus_timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hold_ctrl #(.WAIT_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_wait_i     (mem_wait_i),
    .jump_req_i     (jump_req_i),
    .jump_addr_i    (jump_addr_i),
    .ex_busy_i      (ex_busy_i),
    .load_use_i     (load_use_i),
    .hold_pc_o      (hold_pc_o),
    .hold_if_id_o   (hold_if_id_o),
    .hold_id_ex_o   (hold_id_ex_o),
    .hold_ex_mem_o  (hold_ex_mem_o),
    .hold_mem_wb_o  (hold_mem_wb_o),
    .pc_jump_en_o   (pc_jump_en_o),
    .pc_jump_addr_o (pc_jump_addr_o),
    .jump_pend_o    (jump_pend_o),
    .bus_timeout_o  (bus_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [9:0] holds, input logic jen,
                           input logic [31:0] jaddr, input logic jpend, input logic tout);
    chk({tag, ".holds"}, 32'({hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o}), 32'(holds));
    chk({tag, ".jump_en"}, 32'(pc_jump_en_o), 32'(jen));
    chk({tag, ".jump_addr"}, pc_jump_addr_o, jaddr);
    chk({tag, ".pend"}, 32'(jump_pend_o), 32'(jpend));
    chk({tag, ".timeout"}, 32'(bus_timeout_o), 32'(tout));
  endtask

  // Advance to 1 time unit after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_wait_i  = 1'b0;
    jump_req_i  = 1'b0;
    jump_addr_i = '0;
    ex_busy_i   = 1'b0;
    load_use_i  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with active inputs: outputs must still be idle.
    rst_n       = 1'b0;
    mem_wait_i  = 1'b1;
    jump_req_i  = 1'b1;
    jump_addr_i = 32'h300;
    ex_busy_i   = 1'b1;
    load_use_i  = 1'b1;
    #3;
    check_all("reset_active_in", ALLN, 0, 32'h0, 0, 0);
    cyc();
    check_all("reset_held", ALLN, 0, 32'h0, 0, 0);
    idle_inputs();
    cyc();
    rst_n = 1'b1;
    #3;
    check_all("idle", ALLN, 0, 32'h0, 0, 0);

    // Load-use for one cycle.
    cyc(); load_use_i = 1'b1; #3;
    check_all("load_use", LU, 0, 32'h0, 0, 0);
    cyc(); load_use_i = 1'b0; #3;
    check_all("load_use_after", ALLN, 0, 32'h0, 0, 0);

    // Live jump, no wait.
    cyc(); jump_req_i = 1'b1; jump_addr_i = 32'h100; #3;
    check_all("jump_live", REDIR, 1, 32'h100, 0, 0);
    cyc(); idle_inputs(); #3;
    check_all("jump_live_after", ALLN, 0, 32'h0, 0, 0);

    // Jump during a 3-cycle wait, released on cycle 4.
    cyc(); mem_wait_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h200; #3;
    check_all("wait_c1", ALLW, 0, 32'h0, 0, 0);
    cyc(); jump_req_i = 1'b0; jump_addr_i = '0; #3;
    check_all("wait_c2", ALLW, 0, 32'h0, 1, 0);
    cyc(); #3;
    check_all("wait_c3", ALLW, 0, 32'h0, 1, 0);
    cyc(); mem_wait_i = 1'b0; #3;
    check_all("pend_release", REDIR, 1, 32'h200, 1, 0);
    cyc(); #3;
    check_all("pend_after", ALLN, 0, 32'h0, 0, 0);

    // Latest capture wins; simultaneous live jump at release is ignored.
    cyc(); mem_wait_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h400; #3;
    check_all("overwrite_c1", ALLW, 0, 32'h0, 0, 0);
    cyc(); jump_addr_i = 32'h440; #3;
    check_all("overwrite_c2", ALLW, 0, 32'h0, 1, 0);
    cyc(); mem_wait_i = 1'b0; jump_addr_i = 32'h999; #3;
    check_all("overwrite_release", REDIR, 1, 32'h440, 1, 0);
    cyc(); idle_inputs(); #3;
    check_all("overwrite_after", ALLN, 0, 32'h0, 0, 0);

    // ex_busy and load_use together: ex_busy wins for all 4 cycles.
    for (int i = 0; i < 4; i++) begin
      cyc(); ex_busy_i = 1'b1; load_use_i = 1'b1; #3;
      check_all($sformatf("exbusy_lu_%0d", i), EXB, 0, 32'h0, 0, 0);
    end
    // A live jump beats ex_busy/load_use.
    cyc(); jump_req_i = 1'b1; jump_addr_i = 32'h500; #3;
    check_all("jump_over_busy", REDIR, 1, 32'h500, 0, 0);
    cyc(); jump_req_i = 1'b0; load_use_i = 1'b0; #3;
    check_all("exbusy_only", EXB, 0, 32'h0, 0, 0);
    cyc(); idle_inputs(); #3;
    check_all("busy_after", ALLN, 0, 32'h0, 0, 0);

    // Timeout: 10 wait cycles, one pulse on the 4th.
    for (int i = 0; i < 10; i++) begin
      cyc(); mem_wait_i = 1'b1; #3;
      chk($sformatf("timeout_run1_%0d", i), 32'(bus_timeout_o), (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("timeout_holds_%0d", i), 32'(hold_mem_wb_o), 32'(W));
    end
    cyc(); mem_wait_i = 1'b0; #3;
    check_all("timeout_gap", ALLN, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); mem_wait_i = 1'b1; #3;
      chk($sformatf("timeout_run2_%0d", i), 32'(bus_timeout_o), (i == 3) ? 32'd1 : 32'd0);
    end
    cyc(); mem_wait_i = 1'b0; #3;
    chk("timeout_end", 32'(bus_timeout_o), 32'd0);

    // Reset while PEND discards the pending jump.
    cyc(); mem_wait_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h300; #3;
    check_all("rst_pend_c1", ALLW, 0, 32'h0, 0, 0);
    cyc(); jump_req_i = 1'b0; jump_addr_i = '0; #3;
    check_all("rst_pend_c2", ALLW, 0, 32'h0, 1, 0);
    cyc(); mem_wait_i = 1'b0; rst_n = 1'b0; #3;
    check_all("rst_in_pend", ALLN, 0, 32'h0, 0, 0);
    cyc(); rst_n = 1'b1; #3;
    check_all("rst_release", ALLN, 0, 32'h0, 0, 0);
    cyc(); #3;
    check_all("rst_release_2", ALLN, 0, 32'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 255, range 1..255: the number of consecutive mem_wait cycles that raises bus_timeout_o.
REQ-002 Hold encoding (holdpip_bus, 2 bits) SHALL be: hold_none = 2'b00, hold_wait = 2'b01, hold_flush = 2'b10; 2'b11 is never driven.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 mem_wait_i  in  1  MEM-stage bus not ready; the whole pipeline must freeze.
REQ-006 jump_req_i  in  1  EX resolved a taken jump or branch mispredict.
REQ-007 jump_addr_i  in  32  redirect target, valid while jump_req_i=1.
REQ-008 ex_busy_i  in  1  multi-cycle EX operation (mul/div) is not yet done.
REQ-009 load_use_i  in  1  ID detected a load-use hazard.
REQ-010 hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o  out  2 each  per-stage hold command; the pipeline registers consume these.
REQ-011 pc_jump_en_o  out  1  redirect PC this cycle.
REQ-012 pc_jump_addr_o  out  32  redirect target.
REQ-013 jump_pend_o  out  1  a jump is latched and awaiting release.
REQ-014 bus_timeout_o  out  1  one-cycle pulse on the wait timeout.

Function
REQ-015 FSM states SHALL be RUN and PEND; PEND holds a latched jump (pend_addr, 32-bit register).
- RUN -> PEND: mem_wait_i=1 and jump_req_i=1 in the same cycle.
- PEND -> RUN: first cycle with mem_wait_i=0.
REQ-016 Outputs SHALL be combinational from state and inputs, with priority mem_wait > jump (live or pending) > ex_busy > load_use > none.
REQ-017 When mem_wait_i=1, all five hold outputs SHALL be hold_wait and pc_jump_en_o SHALL be 0.
REQ-018 When mem_wait_i=1 and jump_req_i=1, pend_addr SHALL capture jump_addr_i; a later capture in PEND overwrites it (the latest value wins).
REQ-019 When mem_wait_i=0 and the state is PEND, the controller SHALL redirect:
- pc_jump_en_o=1, pc_jump_addr_o=pend_addr;
- hold_if_id_o = hold_id_ex_o = hold_flush;
- all other holds = hold_none.
- A simultaneous jump_req_i is ignored, because it is the same instruction.
REQ-020 When mem_wait_i=0, the state is RUN and jump_req_i=1, the controller SHALL apply the same redirect pattern as REQ-019 with pc_jump_addr_o=jump_addr_i; ex_busy_i and load_use_i are ignored that cycle.
REQ-021 When ex_busy_i=1 and no higher-priority condition is active:
- hold_pc_o, hold_if_id_o, hold_id_ex_o = hold_wait;
- hold_ex_mem_o = hold_flush (bubble);
- hold_mem_wb_o = hold_none.
REQ-022 When load_use_i=1 and no higher-priority condition is active:
- hold_pc_o, hold_if_id_o = hold_wait;
- hold_id_ex_o = hold_flush;
- all others = hold_none.
REQ-023 When no condition is active, all holds SHALL be hold_none, pc_jump_en_o=0 and pc_jump_addr_o=0.
REQ-024 jump_pend_o SHALL be 1 exactly when the state is PEND.
REQ-025 Wait counter, 8 bits:
- increments each cycle mem_wait_i=1, saturating at WAIT_TIMEOUT;
- clears on any cycle mem_wait_i=0.
REQ-026 bus_timeout_o SHALL be high for exactly one cycle, the cycle the counter reaches WAIT_TIMEOUT, and SHALL not re-pulse until the counter has been cleared.

Reset
REQ-027 While rst_n=0: state=RUN, pend_addr=0, counter=0, all holds = hold_none, pc_jump_en_o=0, pc_jump_addr_o=0, jump_pend_o=0, bus_timeout_o=0.
REQ-028 A reset asserted in PEND SHALL discard the pending jump; no redirect is issued after reset release.

Verification
REQ-029 load_use_i=1 for 1 cycle -> that cycle: pc/if_id wait, id_ex flush (2'b10), ex_mem/mem_wb none; next cycle all none.
REQ-030 jump_req_i=1, jump_addr_i=0x0000_0100, no wait -> same cycle: pc_jump_en_o=1, addr 0x100, if_id/id_ex flush, jump_pend_o stays 0.
REQ-031 mem_wait_i=1 for 3 cycles with jump_req_i=1 addr 0x200 on cycle 1 -> holds all wait for 3 cycles, jump_pend_o=1 from cycle 2; cycle 4: redirect to 0x200, then RUN.
REQ-032 ex_busy_i=1 and load_use_i=1 together for 4 cycles -> ex_busy pattern (ex_mem flush, id_ex wait) all 4 cycles.
REQ-033 WAIT_TIMEOUT=4, mem_wait_i=1 for 10 cycles -> bus_timeout_o pulses once, in the 4th wait cycle; wait drops then rises for 4 cycles -> a second pulse.
REQ-034 In PEND with addr 0x300, pull rst_n low for 1 cycle, then keep mem_wait_i=0 -> no pc_jump_en_o, all outputs at reset values.
